multicycle_controller: RTL
==========================

# multicycle_controller

Parametrised multi-cycle control unit for the single-cycle processor's next-generation datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and stalls on a memory ready handshake. Per state, it drives the same control set as the existing single-cycle decoder, plus PC/IR write enables, an illegal-opcode trap and a retired-instruction counter. It sits between the instruction register (opcode source), the shared instruction/data memory port and the datapath muxes.

## Interface
Parameters:
- OPC_W, 6, opcode width (≥6). Opcode constants below are zero-extended to OPC_W.
- ALUOP_W, 2, alu_op width (≥2). Codes are zero-extended.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  OPC_W  opcode field from the external instruction register. Valid from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request (FETCH, MEM).
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- ir_write  out  1  load instruction register.
- pc_write  out  1  PC ← PC+4 (FETCH completion).
- reg_write  out  1  register file write.
- alu_src  out  1  ALU B = immediate.
- mem_to_reg  out  1  writeback data from memory.
- branch  out  1  conditional branch evaluate (EXEC).
- branch_ne  out  1  branch condition inverted (BNE).
- jump  out  1  PC ← jump target (EXEC).
- alu_op  out  ALUOP_W  00 add, 01 sub, 10 use funct.
- trap  out  1  one-cycle pulse on an illegal opcode.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- state  out  3  current state, for debug.
- retired  out  CNT_W  count of completed legal instructions; wraps modulo 2^CNT_W.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Codes 6 and 7 are unreachable and recover to IDLE.
- IDLE→FETCH unconditionally. IDLE is entered only from reset.
- FETCH: mem_req=1, mem_read=1. When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise hold FETCH.
- DECODE: latch opcode into op_q.
  - Illegal opcode: trap=1, go to FETCH. The counter does not increment.
  - Otherwise go to EXEC.
- Legal opcodes and paths:
  - R-type 000000: EXEC (alu_op=10) → WB (reg_write).
  - LW 100011: EXEC (alu_src, alu_op=00) → MEM (mem_read) → WB (reg_write, mem_to_reg).
  - SW 101011: EXEC (alu_src, alu_op=00) → MEM (mem_write) → FETCH.
  - BEQ 000100: EXEC (branch, alu_op=01) → FETCH.
  - BNE 000101: EXEC (branch, branch_ne, alu_op=01) → FETCH.
  - J 000010: EXEC (jump) → FETCH.
  - ADDI 001000: EXEC (alu_src, alu_op=00) → WB (reg_write).
- EXEC and later states decode from op_q, never from the live opcode input.
- MEM: mem_req=1 plus mem_read or mem_write. Hold MEM until mem_ready=1, with outputs held stable.
- instr_done=1 and retired+1 in the terminal cycle:
  - WB;
  - MEM for SW (on mem_ready);
  - EXEC for BEQ/BNE/J.
- Every output not listed for a state is 0.
- mem_ready is ignored outside FETCH and MEM.

## Timing
- All outputs except state/retired are combinational from the state register and op_q. There are no mem_ready combinational paths, except:
  - ir_write and pc_write in FETCH;
  - instr_done in SW MEM.
- Reset low: state=IDLE, op_q=0, retired=0, all control outputs 0, taking effect immediately (asynchronous).
- The first FETCH is on the first rising edge after reset deasserts.
- Reset mid-instruction aborts it. The partial instruction is not counted, and no stray write occurs after reset asserts.
- Zero-wait cycle counts, FETCH to last cycle inclusive: R/ADDI 4, LW 5, SW 4, BEQ/BNE/J 3, illegal 2.
- Each wait cycle (mem_ready=0 in FETCH or MEM) adds exactly 1 cycle.
- Back-to-back operation: FETCH follows the terminal state with no bubble.
- Counter at 2^CNT_W−1 wraps to 0 on the next retirement.

## Test plan
- Reset, then R-type with mem_ready=1 always:
  - state sequence 0,1,2,3,5,1;
  - reg_write=1 only in WB, alu_op=10 in EXEC;
  - retired=1 after WB.
- LW with mem_ready low for 2 cycles in MEM:
  - MEM lasts 3 cycles with mem_req/mem_read held;
  - WB has mem_to_reg=1, reg_write=1;
  - total 7 cycles.
- SW, then BNE, then J, back-to-back:
  - mem_write only in MEM, with instr_done there;
  - BNE EXEC has branch=1, branch_ne=1, alu_op=01;
  - J EXEC has jump=1;
  - retired=3.
- Opcode 111111: trap pulses for 1 cycle in DECODE, next state FETCH, retired unchanged, no reg_write/mem_write.
- Change the opcode input during EXEC/MEM of an LW: outputs still follow the LW path (op_q holds the decoded opcode).
- Async reset asserted mid-MEM of SW: all outputs 0 immediately, state=0, retired=0. With CNT_W=2, 4 retirements bring retired back to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready,
// drives datapath controls, traps illegal opcodes and counts retired instructions.
module multicycle_controller #(
   parameter int OPC_W   = 6,
   parameter int ALUOP_W = 2,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OPC_W-1:0]   opcode,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               pc_write,
   output logic               reg_write,
   output logic               alu_src,
   output logic               mem_to_reg,
   output logic               branch,
   output logic               branch_ne,
   output logic               jump,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               trap,
   output logic               instr_done,
   output logic [2:0]         state,
   output logic [CNT_W-1:0]   retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
   localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
   localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
   localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
   localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(6'b000101);
   localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);
   localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

   state_t            state_reg, state_next;
   logic [OPC_W-1:0]  op_q;
   logic [CNT_W-1:0]  retired_reg;
   logic              legal_dec;

   // Legality is judged on the live opcode, since op_q is only captured at the end of DECODE
   assign legal_dec = (opcode == OP_R)   || (opcode == OP_LW)  || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_J)  ||
                      (opcode == OP_ADDI);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= S_IDLE;
         op_q        <= '0;
         retired_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_DECODE)
            op_q <= opcode;
         if (instr_done)
            retired_reg <= retired_reg + CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state_reg;
      mem_req    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      jump       = 1'b0;
      alu_op     = ALU_ADD;
      trap       = 1'b0;
      instr_done = 1'b0;
      case (state_reg)
         S_IDLE: state_next = S_FETCH;
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (legal_dec) begin
               state_next = S_EXEC;
            end else begin
               trap       = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_EXEC: begin
            state_next = S_FETCH;
            case (op_q)
               OP_R: begin
                  alu_op     = ALU_FUNCT;
                  state_next = S_WB;
               end
               OP_LW, OP_SW: begin
                  alu_src    = 1'b1;
                  state_next = S_MEM;
               end
               OP_ADDI: begin
                  alu_src    = 1'b1;
                  state_next = S_WB;
               end
               OP_BEQ, OP_BNE: begin
                  branch     = 1'b1;
                  branch_ne  = (op_q == OP_BNE);
                  alu_op     = ALU_SUB;
                  instr_done = 1'b1;
               end
               OP_J: begin
                  jump       = 1'b1;
                  instr_done = 1'b1;
               end
               default: state_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            if (op_q == OP_SW) begin
               mem_write = 1'b1;
               if (mem_ready) begin
                  instr_done = 1'b1;
                  state_next = S_FETCH;
               end
            end else begin
               mem_read = 1'b1;
               if (mem_ready)
                  state_next = S_WB;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (op_q == OP_LW);
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign state   = state_reg;
   assign retired = retired_reg;

endmodule
